// File: rtl/algo_1r1w_a421_pkg.sv
// Shared definitions for the read-error logger.
// Holds the default parameter widths and the log-entry type encoding used by
// algo_1r1w_a421_errlog and its FIFO.
package algo_1r1w_a421_pkg;

  // Physical address = bank(3) + row(11) + word(1) + 1.
  localparam int BITPADR_DEF = 16;
  localparam int LOGDPTH_DEF = 8;
  localparam int BITLOGD_DEF = 3;
  localparam int CNTWDTH_DEF = 16;

  typedef enum logic {
    LOG_SERR = 1'b0,
    LOG_DERR = 1'b1
  } log_type_e;

endpackage

// File: rtl/algo_1r1w_a421_errlog_fifo.sv
// Flop-based FIFO holding logged error entries.
// Ports:
//   clk, rst      - clock, async active-high reset (pointers only)
//   push, wdata   - write request; accepted if not full, or if full and popping
//   pop           - remove head; ignored while empty
//   rdata         - head entry, read combinationally from storage
//   full, empty   - occupancy flags
// Pointers carry one extra bit so full and empty are distinguishable.
module algo_errlog_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_en = pop && !empty;
  // A full FIFO frees its head slot this cycle when popped, so the push fits.
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is qualified by !empty at the top level.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/algo_1r1w_a421_errlog.sv
// Read-error logger: classifies ECC read returns, queues their addresses for
// a scrub engine and keeps saturating per-type error counters.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   ready                    - memory ready; read returns ignored while low
//   rd_vld/rd_serr/rd_derr   - read return valid and its error flags
//   rd_padr                  - physical address of the read return
//   log_vld/log_padr/log_derr- head log entry (address, 1 = double-bit)
//   log_pop                  - consumer removes the head entry
//   cnt_clr                  - synchronous clear of counters and overflow
//   serr_cnt/derr_cnt        - saturating error counters
//   log_ovfl                 - sticky: an event was dropped on a full log
// Handshake: the head entry transfers on a cycle where log_vld && log_pop;
// log_pop with log_vld low has no effect.
module algo_1r1w_a421_errlog
  import algo_1r1w_a421_pkg::*;
#(
  parameter int BITPADR = BITPADR_DEF,
  parameter int LOGDPTH = LOGDPTH_DEF,
  parameter int BITLOGD = BITLOGD_DEF,
  parameter int CNTWDTH = CNTWDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               rd_vld,
  input  logic               rd_serr,
  input  logic               rd_derr,
  input  logic [BITPADR-1:0] rd_padr,
  output logic               log_vld,
  output logic [BITPADR-1:0] log_padr,
  output logic               log_derr,
  input  logic               log_pop,
  input  logic               cnt_clr,
  output logic [CNTWDTH-1:0] serr_cnt,
  output logic [CNTWDTH-1:0] derr_cnt,
  output logic               log_ovfl
);

  localparam logic [CNTWDTH-1:0] CNT_MAX = '1;

  logic          evt;
  log_type_e     evt_type;
  logic          evt_serr;
  logic          evt_derr;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [BITPADR:0] head;

  assign evt      = ready && rd_vld && (rd_serr || rd_derr);
  // A return flagged with both errors is uncorrectable; it counts as double only.
  assign evt_type = rd_derr ? LOG_DERR : LOG_SERR;
  assign evt_serr = evt && (evt_type == LOG_SERR);
  assign evt_derr = evt && (evt_type == LOG_DERR);
  assign drop     = evt && fifo_full && !(log_pop && log_vld);

  algo_errlog_fifo #(
    .DEPTH (LOGDPTH),
    .AW    (BITLOGD),
    .W     (BITPADR + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .pop   (log_pop),
    .wdata ({rd_padr, evt_type}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields are forced to zero while empty so reset clears them at once.
  assign log_vld  = !fifo_empty;
  assign log_padr = log_vld ? head[BITPADR:1] : '0;
  assign log_derr = log_vld && (head[0] == LOG_DERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serr_cnt <= '0;
      derr_cnt <= '0;
      log_ovfl <= 1'b0;
    end else if (cnt_clr) begin
      // Clear wins over history but not over this cycle's event.
      serr_cnt <= evt_serr ? CNTWDTH'(1) : '0;
      derr_cnt <= evt_derr ? CNTWDTH'(1) : '0;
      log_ovfl <= drop;
    end else begin
      if (evt_serr && serr_cnt != CNT_MAX) serr_cnt <= serr_cnt + 1'b1;
      if (evt_derr && derr_cnt != CNT_MAX) derr_cnt <= derr_cnt + 1'b1;
      if (drop) log_ovfl <= 1'b1;
    end
  end

endmodule
